// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU MEM stage and the DMA/debug loader port.
// Define DMEM_ARBITER_STATS_EN to build the stall/grant statistics counters.
module dmem_arbiter #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [1:0]        cpu_size_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic              cpu_gnt_o,
   output logic              cpu_stall_o,
   output logic              cpu_rvalid_o,
   output logic [DATA_W-1:0] cpu_rdata_o,

   input  logic              dma_req_i,
   input  logic              dma_we_i,
   input  logic [1:0]        dma_size_i,
   input  logic [ADDR_W-1:0] dma_addr_i,
   input  logic [DATA_W-1:0] dma_wdata_i,
   output logic              dma_gnt_o,
   output logic              dma_rvalid_o,
   output logic [DATA_W-1:0] dma_rdata_o,

   output logic [ADDR_W-1:0] mem_address_o,
   output logic [DATA_W-1:0] mem_write_data_o,
   output logic [1:0]        mem_ctrl_read_o,
   output logic [1:0]        mem_ctrl_write_o,
   input  logic [DATA_W-1:0] mem_read_data_i,

   output logic [15:0]       stat_cpu_stall_o,
   output logic [15:0]       stat_dma_gnt_o
);

   // Memory size encoding for "no access" (BYTE=01, HALFWORD=10, WORD=11)
   localparam logic [1:0]        SIZE_NONE = 2'b00;
   localparam int unsigned       WAIT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

   logic              cpu_gnt_c;
   logic              dma_gnt_c;
   logic              dma_force_c;
   logic              sel_we_c;
   logic [1:0]        sel_size_c;
   logic [ADDR_W-1:0] sel_addr_c;
   logic [DATA_W-1:0] sel_wdata_c;

   logic [WAIT_W-1:0] wait_cnt_q;
   logic              rd_pend_q;
   logic              rd_dma_q;

   // DMA is forced through once it has been denied MAX_WAIT cycles in a row
   assign dma_force_c = dma_req_i && (wait_cnt_q == WAIT_MAX);

   always_comb begin
      cpu_gnt_c = 1'b0;
      dma_gnt_c = 1'b0;
      if (!rst_i) begin
         if (dma_force_c) begin
            dma_gnt_c = 1'b1;
         end else if (cpu_req_i) begin
            cpu_gnt_c = 1'b1;
         end else if (dma_req_i) begin
            dma_gnt_c = 1'b1;
         end
      end
   end

   assign cpu_gnt_o   = cpu_gnt_c;
   assign dma_gnt_o   = dma_gnt_c;
   assign cpu_stall_o = cpu_req_i & ~cpu_gnt_c;

   always_comb begin
      sel_we_c    = cpu_we_i;
      sel_size_c  = cpu_size_i;
      sel_addr_c  = cpu_addr_i;
      sel_wdata_c = cpu_wdata_i;
      if (dma_gnt_c) begin
         sel_we_c    = dma_we_i;
         sel_size_c  = dma_size_i;
         sel_addr_c  = dma_addr_i;
         sel_wdata_c = dma_wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_cnt_q <= '0;
      end else if (!dma_req_i || dma_gnt_c) begin
         wait_cnt_q <= '0;
      end else if (wait_cnt_q != WAIT_MAX) begin
         wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
   end

   // Issue stage: drive the memory bus and tag the access with its owner
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_address_o    <= '0;
         mem_write_data_o <= '0;
         mem_ctrl_read_o  <= SIZE_NONE;
         mem_ctrl_write_o <= SIZE_NONE;
         rd_pend_q        <= 1'b0;
         rd_dma_q         <= 1'b0;
      end else begin
         mem_ctrl_read_o  <= SIZE_NONE;
         mem_ctrl_write_o <= SIZE_NONE;
         rd_pend_q        <= 1'b0;
         if (cpu_gnt_c || dma_gnt_c) begin
            mem_address_o    <= sel_addr_c;
            mem_write_data_o <= sel_wdata_c;
            rd_pend_q        <= ~sel_we_c;
            rd_dma_q         <= dma_gnt_c;
            if (sel_we_c) begin
               mem_ctrl_write_o <= sel_size_c;
            end else begin
               mem_ctrl_read_o  <= sel_size_c;
            end
         end
      end
   end

   // Response stage: capture read data and steer it to the owning port
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cpu_rvalid_o <= 1'b0;
         dma_rvalid_o <= 1'b0;
         cpu_rdata_o  <= '0;
         dma_rdata_o  <= '0;
      end else begin
         cpu_rvalid_o <= rd_pend_q & ~rd_dma_q;
         dma_rvalid_o <= rd_pend_q & rd_dma_q;
         if (rd_pend_q && !rd_dma_q) begin
            cpu_rdata_o <= mem_read_data_i;
         end
         if (rd_pend_q && rd_dma_q) begin
            dma_rdata_o <= mem_read_data_i;
         end
      end
   end

`ifdef DMEM_ARBITER_STATS_EN
   logic [15:0] stall_cnt_q;
   logic [15:0] dma_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         dma_cnt_q   <= '0;
      end else begin
         if (cpu_stall_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if (dma_gnt_c && (dma_cnt_q != 16'hFFFF)) begin
            dma_cnt_q <= dma_cnt_q + 16'd1;
         end
      end
   end

   assign stat_cpu_stall_o = stall_cnt_q;
   assign stat_dma_gnt_o   = dma_cnt_q;
`else
   assign stat_cpu_stall_o = '0;
   assign stat_dma_gnt_o   = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter: a transaction-level reference model predicts
// grants, bus contents and steered read responses, with directed scenarios around it.
module tb_dmem_arbiter;

   localparam int unsigned ADDR_W   = 8;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned MAX_WAIT = 4;

   localparam logic [1:0] SZ_NONE = 2'b00;
   localparam logic [1:0] SZ_BYTE = 2'b01;
   localparam logic [1:0] SZ_HALF = 2'b10;
   localparam logic [1:0] SZ_WORD = 2'b11;

   logic              clk_i = 1'b0;
   logic              rst_i;
   logic              cpu_req_i, cpu_we_i;
   logic [1:0]        cpu_size_i;
   logic [ADDR_W-1:0] cpu_addr_i;
   logic [DATA_W-1:0] cpu_wdata_i;
   logic              cpu_gnt_o, cpu_stall_o, cpu_rvalid_o;
   logic [DATA_W-1:0] cpu_rdata_o;
   logic              dma_req_i, dma_we_i;
   logic [1:0]        dma_size_i;
   logic [ADDR_W-1:0] dma_addr_i;
   logic [DATA_W-1:0] dma_wdata_i;
   logic              dma_gnt_o, dma_rvalid_o;
   logic [DATA_W-1:0] dma_rdata_o;
   logic [ADDR_W-1:0] mem_address_o;
   logic [DATA_W-1:0] mem_write_data_o;
   logic [1:0]        mem_ctrl_read_o, mem_ctrl_write_o;
   logic [DATA_W-1:0] mem_read_data_i;
   logic [15:0]       stat_cpu_stall_o, stat_dma_gnt_o;

   always #5 clk_i = ~clk_i;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_size_i(cpu_size_i),
      .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
      .cpu_gnt_o(cpu_gnt_o), .cpu_stall_o(cpu_stall_o),
      .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
      .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_size_i(dma_size_i),
      .dma_addr_i(dma_addr_i), .dma_wdata_i(dma_wdata_i),
      .dma_gnt_o(dma_gnt_o), .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o),
      .mem_address_o(mem_address_o), .mem_write_data_o(mem_write_data_o),
      .mem_ctrl_read_o(mem_ctrl_read_o), .mem_ctrl_write_o(mem_ctrl_write_o),
      .mem_read_data_i(mem_read_data_i),
      .stat_cpu_stall_o(stat_cpu_stall_o), .stat_dma_gnt_o(stat_dma_gnt_o)
   );

   function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz);
      case (sz)
         SZ_BYTE: return {{24{w[7]}}, w[7:0]};
         SZ_HALF: return {{16{w[15]}}, w[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] d,
                                               input logic [1:0] sz);
      case (sz)
         SZ_BYTE: return {old[31:8], d[7:0]};
         SZ_HALF: return {old[31:16], d[15:0]};
         default: return d;
      endcase
   endfunction

   // Data memory seen by the DUT: combinational sign-extending read, clocked write
   logic [31:0] dmem [256];
   assign mem_read_data_i = load_ext(dmem[mem_address_o], mem_ctrl_read_o);
   always @(posedge clk_i) begin
      if (mem_ctrl_write_o != SZ_NONE)
         dmem[mem_address_o] <= store_merge(dmem[mem_address_o], mem_write_data_o, mem_ctrl_write_o);
   end

   typedef struct packed {
      logic        v;
      logic        dma;
      logic        we;
      logic [1:0]  size;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } acc_t;

   logic [31:0] ref_mem [256];
   acc_t        s1, s2;
   int unsigned starve;
   logic [31:0] exp_crd, exp_drd;
   int unsigned st_stall, st_dma;
   bit          model_ok;
   int unsigned n_chk, n_pass;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
   endtask

   // Called at a negedge with this cycle's inputs applied; returns at the next negedge
   task automatic tick();
      acc_t cur;
      bit   cw, dw, dreq, creq, rst;
      logic [31:0] exp_st, exp_dg;
      #1;
      rst  = rst_i;
      creq = cpu_req_i;
      dreq = dma_req_i;
      cw = 1'b0;
      dw = 1'b0;
      if (!rst) begin
         if (dreq && starve >= MAX_WAIT) dw = 1'b1;
         else if (creq)                  cw = 1'b1;
         else if (dreq)                  dw = 1'b1;
      end
      check("cpu_gnt", 32'(cpu_gnt_o), 32'(cw));
      check("dma_gnt", 32'(dma_gnt_o), 32'(dw));
      check("cpu_stall", 32'(cpu_stall_o), 32'(creq && !cw));
      if (model_ok) begin
         check("ctrl_read", 32'(mem_ctrl_read_o), 32'((s1.v && !s1.we) ? s1.size : SZ_NONE));
         check("ctrl_write", 32'(mem_ctrl_write_o), 32'((s1.v && s1.we) ? s1.size : SZ_NONE));
         if (s1.v) check("mem_addr", 32'(mem_address_o), 32'(s1.addr));
         if (s1.v && s1.we) check("mem_wdata", mem_write_data_o, s1.wdata);
         if (s2.v && !s2.we && !s2.dma) exp_crd = s2.rdata;
         if (s2.v && !s2.we && s2.dma)  exp_drd = s2.rdata;
         check("cpu_rvalid", 32'(cpu_rvalid_o), 32'(s2.v && !s2.we && !s2.dma));
         check("dma_rvalid", 32'(dma_rvalid_o), 32'(s2.v && !s2.we && s2.dma));
         check("cpu_rdata", cpu_rdata_o, exp_crd);
         check("dma_rdata", dma_rdata_o, exp_drd);
`ifdef DMEM_ARBITER_STATS_EN
         exp_st = st_stall;
         exp_dg = st_dma;
`else
         exp_st = 32'd0;
         exp_dg = 32'd0;
`endif
         check("stat_stall", 32'(stat_cpu_stall_o), exp_st);
         check("stat_dma", 32'(stat_dma_gnt_o), exp_dg);
      end
      cur = '0;
      if (cw || dw) begin
         cur.v     = 1'b1;
         cur.dma   = dw;
         cur.we    = dw ? dma_we_i : cpu_we_i;
         cur.size  = dw ? dma_size_i : cpu_size_i;
         cur.addr  = dw ? dma_addr_i : cpu_addr_i;
         cur.wdata = dw ? dma_wdata_i : cpu_wdata_i;
         if (cur.we) ref_mem[cur.addr] = store_merge(ref_mem[cur.addr], cur.wdata, cur.size);
         else        cur.rdata = load_ext(ref_mem[cur.addr], cur.size);
      end
      @(posedge clk_i);
      if (rst) begin
         s1 = '0; s2 = '0; starve = 0;
         exp_crd = '0; exp_drd = '0;
         st_stall = 0; st_dma = 0;
         model_ok = 1'b1;
      end else begin
         s2 = s1;
         s1 = cur;
         if (!dreq || dw)           starve = 0;
         else if (starve < MAX_WAIT) starve++;
         if (creq && !cw && st_stall < 65535) st_stall++;
         if (dw && st_dma < 65535)            st_dma++;
      end
      @(negedge clk_i);
   endtask

   task automatic idle();
      cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_size_i = SZ_WORD; cpu_addr_i = '0; cpu_wdata_i = '0;
      dma_req_i = 1'b0; dma_we_i = 1'b0; dma_size_i = SZ_WORD; dma_addr_i = '0; dma_wdata_i = '0;
   endtask

   task automatic do_reset(input int n);
      idle();
      rst_i = 1'b1;
      repeat (n) tick();
      rst_i = 1'b0;
   endtask

   task automatic rand_inputs(input int pc, input int pd);
      cpu_req_i   = ($urandom_range(99) < pc);
      cpu_we_i    = $urandom_range(1);
      cpu_size_i  = 2'($urandom_range(3, 1));
      cpu_addr_i  = 8'($urandom);
      cpu_wdata_i = $urandom;
      dma_req_i   = ($urandom_range(99) < pd);
      dma_we_i    = $urandom_range(1);
      dma_size_i  = 2'($urandom_range(3, 1));
      dma_addr_i  = 8'($urandom);
      dma_wdata_i = $urandom;
   endtask

   task automatic dma_write(input logic [7:0] a, input logic [31:0] d);
      idle();
      dma_req_i = 1'b1; dma_we_i = 1'b1; dma_size_i = SZ_WORD; dma_addr_i = a; dma_wdata_i = d;
      tick();
   endtask

   initial begin
      n_chk = 0; n_pass = 0; model_ok = 1'b0;
      s1 = '0; s2 = '0; starve = 0; exp_crd = '0; exp_drd = '0; st_stall = 0; st_dma = 0;
      idle();
      rst_i = 1'b1;
      @(negedge clk_i);
      do_reset(3);

      #1;
      check("rst_addr", 32'(mem_address_o), 32'd0);
      check("rst_wdata", mem_write_data_o, 32'd0);

      // Load the whole memory through the DMA port
      for (int a = 0; a < 256; a++) dma_write(8'(a), $urandom);
      dma_write(8'h05, 32'h000000F0);
      dma_write(8'h01, 32'h00000011);
      dma_write(8'h02, 32'h00000022);

      // Reset arriving while a CPU read is on the memory bus
      idle();
      cpu_req_i = 1'b1; cpu_size_i = SZ_WORD; cpu_addr_i = 8'h10;
      tick();
      idle();
      rst_i = 1'b1;
      #1;
      check("midrst_bus", 32'(mem_ctrl_read_o), 32'(SZ_WORD));
      tick();
      rst_i = 1'b0;
      #1;
      check("midrst_rvalid", 32'(cpu_rvalid_o), 32'd0);
      check("midrst_ctrl_rd", 32'(mem_ctrl_read_o), 32'(SZ_NONE));
      check("midrst_addr", 32'(mem_address_o), 32'd0);
      check("midrst_rdata", cpu_rdata_o, 32'd0);
      tick();
      tick();

      // Word write followed directly by a read of the same address
      idle();
      cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_size_i = SZ_WORD;
      cpu_addr_i = 8'h20; cpu_wdata_i = 32'hDEADBEEF;
      #1;
      check("wr_stall", 32'(cpu_stall_o), 32'd0);
      tick();
      cpu_we_i = 1'b0; cpu_wdata_i = '0;
      #1;
      check("rd_stall", 32'(cpu_stall_o), 32'd0);
      tick();
      idle();
      #1;
      check("wr_no_rvalid", 32'(cpu_rvalid_o), 32'd0);
      tick();
      #1;
      check("raw_rvalid", 32'(cpu_rvalid_o), 32'd1);
      check("raw_rdata", cpu_rdata_o, 32'hDEADBEEF);
      tick();

      // Byte read of a negative byte comes back sign-extended
      cpu_req_i = 1'b1; cpu_size_i = SZ_BYTE; cpu_addr_i = 8'h05;
      tick();
      idle();
      #1;
      check("byte_bus", 32'(mem_ctrl_read_o), 32'(SZ_BYTE));
      tick();
      #1;
      check("byte_rvalid", 32'(cpu_rvalid_o), 32'd1);
      check("byte_sext", cpu_rdata_o, 32'hFFFFFFF0);
      tick();

      // Both ports requesting continuously: DMA gets every fifth slot
      do_reset(1);
      cpu_req_i = 1'b1; cpu_size_i = SZ_WORD; cpu_addr_i = 8'h01;
      dma_req_i = 1'b1; dma_size_i = SZ_WORD; dma_addr_i = 8'h02;
      for (int i = 0; i < 20; i++) begin
         #1;
         check("starve_dma_gnt", 32'(dma_gnt_o), 32'((i % 5) == 4));
         check("starve_stall", 32'(cpu_stall_o), 32'((i % 5) == 4));
         tick();
      end
      idle();
      #1;
`ifdef DMEM_ARBITER_STATS_EN
      check("stats_dma_20", 32'(stat_dma_gnt_o), 32'd4);
      check("stats_stall_20", 32'(stat_cpu_stall_o), 32'd4);
`else
      check("stats_dma_off", 32'(stat_dma_gnt_o), 32'd0);
      check("stats_stall_off", 32'(stat_cpu_stall_o), 32'd0);
`endif
      tick();
      tick();

      // Alternating CPU/DMA reads: responses land on the right port two cycles later
      for (int j = 0; j < 10; j++) begin
         idle();
         if (j < 8) begin
            if ((j % 2) == 0) begin
               cpu_req_i = 1'b1; cpu_addr_i = 8'h01;
            end else begin
               dma_req_i = 1'b1; dma_addr_i = 8'h02;
            end
         end
         #1;
         if (j >= 2) begin
            check("steer_cpu_rv", 32'(cpu_rvalid_o), 32'((j % 2) == 0));
            check("steer_dma_rv", 32'(dma_rvalid_o), 32'((j % 2) == 1));
            if ((j % 2) == 0) check("steer_cpu_rd", cpu_rdata_o, 32'h11);
            else              check("steer_dma_rd", dma_rdata_o, 32'h22);
         end
         tick();
      end

      // Random traffic with occasional resets
      for (int k = 0; k < 3000; k++) begin
         if (k < 1500) rand_inputs(60, 60);
         else          rand_inputs(90, 85);
         rst_i = ($urandom_range(199) == 0);
         tick();
      end
      rst_i = 1'b0;
      idle();
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
